// File: rtl/bdpsk_pkg.sv
// Shared types and constants for the DBPSK transmit frame sequencer.
// Holds the frame state enum and the 7-bit PN polynomial definition.
package bdpsk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD,
    DONE
  } state_t;

  localparam int PN_W = 7;

  // Feedback taps c7, c4, c3, c2 as a mask over {c7..c1}
  localparam logic [PN_W:1] PN_TAP_MASK     = 7'b1001110;
  localparam logic [PN_W:1] DEFAULT_PN_SEED = 7'b1001001;

  function automatic logic [PN_W:1] pn_next(input logic [PN_W:1] c);
    return {c[PN_W-1:1], ^(c & PN_TAP_MASK)};
  endfunction

endpackage

// File: rtl/pn7_lfsr.sv
// 7-bit Fibonacci PN generator; output is c7, load overrides advance.
module pn7_lfsr
  import bdpsk_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          adv,
  input  logic [PN_W:1] seed,
  output logic          pn_bit
);

  logic [PN_W:1] c;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c <= seed;
    end else if (load) begin
      c <= seed;
    end else if (adv) begin
      c <= pn_next(c);
    end
  end

  assign pn_bit = c[PN_W];

endmodule

// File: rtl/bdpsk_frame_sequencer.sv
// Frame sequencer for the DBPSK transmit path: PN preamble, sync word, then
// handshaked payload with PN fill, paced by an internal symbol-rate tick.
module bdpsk_frame_sequencer
  import bdpsk_pkg::*;
#(
  parameter int            SYM_DIV      = 8,
  parameter int            PREAMBLE_LEN = 63,
  parameter int            SYNC_LEN     = 16,
  parameter logic [31:0]   SYNC_WORD    = 32'h0000_F0A5,
  parameter int            PAYLOAD_LEN  = 64,
  parameter logic [PN_W:1] PN_SEED      = DEFAULT_PN_SEED
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic bit_out,
  output logic bit_valid,
  output logic busy,
  output logic frame_done,
  output logic underrun
);

  localparam int SYM_W   = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam int MAX_PS  = (PREAMBLE_LEN > SYNC_LEN) ? PREAMBLE_LEN : SYNC_LEN;
  localparam int MAX_LEN = (MAX_PS > PAYLOAD_LEN) ? MAX_PS : PAYLOAD_LEN;
  localparam int BIT_W   = $clog2(MAX_LEN + 1);

  state_t             state, state_nxt;
  logic [SYM_W-1:0]   sym_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               active, tick, start_acc, last_bit, bit_nxt, pn_bit;
  logic [4:0]         sync_idx;

  assign active    = (state == PREAMBLE) || (state == SYNC) || (state == PAYLOAD);
  assign tick      = active && (sym_cnt == SYM_W'(SYM_DIV - 1));
  assign start_acc = (state == IDLE) && start;
  assign sync_idx  = 5'(SYNC_LEN - 1) - 5'(bit_cnt);

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign in_ready   = (state == PAYLOAD) && tick;

  pn7_lfsr u_pn (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (start_acc),
    .adv    (tick),
    .seed   (PN_SEED),
    .pn_bit (pn_bit)
  );

  // NOTE: every variable driven here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    last_bit  = 1'b0;
    bit_nxt   = pn_bit;
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = PREAMBLE;
      PREAMBLE: begin
        last_bit = (bit_cnt == BIT_W'(PREAMBLE_LEN - 1));
        if (tick && last_bit) state_nxt = SYNC;
      end
      SYNC: begin
        last_bit = (bit_cnt == BIT_W'(SYNC_LEN - 1));
        bit_nxt  = SYNC_WORD[sync_idx];
        if (tick && last_bit) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        last_bit = (bit_cnt == BIT_W'(PAYLOAD_LEN - 1));
        if (in_valid) bit_nxt = in_data;
        if (tick && last_bit) state_nxt = DONE;
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      sym_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc || !active || tick) sym_cnt <= '0;
      else                              sym_cnt <= sym_cnt + 1'b1;
      // Bit counter restarts at each state boundary so it indexes within the state
      if (start_acc)     bit_cnt <= '0;
      else if (tick)     bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      bit_valid <= tick;
      if (tick) bit_out <= bit_nxt;
      if (start_acc)                                    underrun <= 1'b0;
      else if (tick && (state == PAYLOAD) && !in_valid) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bdpsk_frame_sequencer.sv
// Randomized self-checking bench for bdpsk_frame_sequencer against a
// sequence-level frame model, over three parameterizations.
module tb_bdpsk_frame_sequencer;

  localparam int          SD [3] = '{1, 8, 1};
  localparam int          PL [3] = '{63, 63, 1};
  localparam int          SL [3] = '{16, 16, 1};
  localparam int          YL [3] = '{64, 64, 1};
  localparam logic [6:0]  SEED   = 7'b1001001;
  localparam logic [31:0] SW     = 32'h0000_F0A5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_data, in_valid;
  logic [2:0] start_v;
  logic [2:0] rdy, bo, bv, bsy, fd, ur;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bdpsk_frame_sequencer #(.SYM_DIV(1), .PREAMBLE_LEN(63), .SYNC_LEN(16), .PAYLOAD_LEN(64)) u_fast (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .bit_out(bo[0]), .bit_valid(bv[0]), .busy(bsy[0]),
    .frame_done(fd[0]), .underrun(ur[0]));

  bdpsk_frame_sequencer #(.SYM_DIV(8), .PREAMBLE_LEN(63), .SYNC_LEN(16), .PAYLOAD_LEN(64)) u_slow (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .bit_out(bo[1]), .bit_valid(bv[1]), .busy(bsy[1]),
    .frame_done(fd[1]), .underrun(ur[1]));

  bdpsk_frame_sequencer #(.SYM_DIV(1), .PREAMBLE_LEN(1), .SYNC_LEN(1), .PAYLOAD_LEN(1)) u_tiny (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[2]), .bit_out(bo[2]), .bit_valid(bv[2]), .busy(bsy[2]),
    .frame_done(fd[2]), .underrun(ur[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: random payload, 1: valid with alternating data, 2: starve slots 10..12,
  // 3: random payload plus start pokes during SYNC and DONE.
  // abort_slot >= 0 pulses reset_n for one clock inside that payload slot.
  task automatic run_frame(input int inst, input int mode, input int abort_slot);
    int   s, pre, sl, pl, n, last_c, abort_c, first_starve, bits_seen, rdy_seen, k, slot;
    logic x        [0:199];
    logic exp_bits [0:199];
    logic obs_bits [0:199];
    logic tick, v, d, bv_exp;
    logic [7:0]  head;
    logic [15:0] sync16;
    s = SD[inst]; pre = PL[inst]; sl = SL[inst]; pl = YL[inst];
    n = pre + sl + pl;
    abort_c      = (abort_slot >= 0) ? (pre + sl + abort_slot) * s + 1 : -1;
    last_c       = (abort_c >= 0) ? abort_c + 4 : n * s + 1;
    first_starve = -1;
    bits_seen    = 0;
    rdy_seen     = 0;
    // PN output sequence as a linear recurrence seeded by {c7..c1}
    for (int i = 0; i < 7; i++) x[i] = SEED[6-i];
    for (int i = 7; i < n; i++) x[i] = x[i-7] ^ x[i-4] ^ x[i-3] ^ x[i-2];
    for (int i = 0; i < n; i++) begin
      exp_bits[i] = x[i];
      obs_bits[i] = 1'b0;
    end
    for (int i = 0; i < sl; i++) exp_bits[pre+i] = SW[sl-1-i];
    start_v[inst] = 1'b1;
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      start_v = '0;
      if (mode == 3 && (c == (pre + 1) * s || c == n * s)) start_v[inst] = 1'b1;
      reset_n = (c == abort_c) ? 1'b0 : 1'b1;
      tick = (c < n * s) && (c % s == s - 1);
      k    = c / s;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 1'($urandom_range(0, 1));
      if (tick && k >= pre + sl) begin
        slot = k - pre - sl;
        v = ($urandom_range(0, 4) != 0);
        d = 1'($urandom_range(0, 1));
        if (mode == 1) begin
          v = 1'b1;
          d = (slot % 2 == 0);
        end
        if (mode == 2) v = !(slot >= 10 && slot <= 12);
        in_valid = v;
        in_data  = d;
        exp_bits[k] = v ? d : x[k];
        if (!v && first_starve < 0) first_starve = c;
      end
      @(negedge clk);
      if (abort_c >= 0 && c > abort_c) begin
        check($sformatf("abort_busy i%0d c%0d", inst, c), bsy[inst], 0);
        check($sformatf("abort_bit_valid i%0d c%0d", inst, c), bv[inst], 0);
        check($sformatf("abort_frame_done i%0d c%0d", inst, c), fd[inst], 0);
        check($sformatf("abort_bit_out i%0d c%0d", inst, c), bo[inst], 0);
        check($sformatf("abort_underrun i%0d c%0d", inst, c), ur[inst], 0);
        check($sformatf("abort_in_ready i%0d c%0d", inst, c), rdy[inst], 0);
      end else begin
        bv_exp = (c >= 1) && (c - 1 < n * s) && ((c - 1) % s == s - 1);
        check($sformatf("bit_valid i%0d c%0d", inst, c), bv[inst], bv_exp);
        if (bv_exp) begin
          obs_bits[(c-1)/s] = bo[inst];
          check($sformatf("bit_out i%0d bit%0d", inst, (c-1)/s), bo[inst], exp_bits[(c-1)/s]);
        end
        if (bv[inst]) bits_seen++;
        if (rdy[inst]) rdy_seen++;
        check($sformatf("busy i%0d c%0d", inst, c), bsy[inst], c <= n * s);
        check($sformatf("frame_done i%0d c%0d", inst, c), fd[inst], c == n * s);
        check($sformatf("in_ready i%0d c%0d", inst, c), rdy[inst], tick && (k >= pre + sl));
        check($sformatf("underrun i%0d c%0d", inst, c), ur[inst],
              (first_starve >= 0) && (c > first_starve));
      end
    end
    reset_n = 1'b1;
    if (abort_c < 0) begin
      check($sformatf("bit_count i%0d", inst), bits_seen, n);
      check($sformatf("ready_count i%0d", inst), rdy_seen, pl);
      if (pre >= 8 && sl == 16) begin
        for (int i = 0; i < 8; i++)  head[7-i]    = obs_bits[i];
        for (int i = 0; i < 16; i++) sync16[15-i] = obs_bits[pre+i];
        check($sformatf("preamble_head i%0d", inst), head, 8'h92);
        check($sformatf("sync_word i%0d", inst), sync16, 16'hF0A5);
      end
    end
  endtask

  task automatic idle_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    start_v  = '0;
    in_data  = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_busy i%0d", i), bsy[i], 0);
      check($sformatf("reset_bit_out i%0d", i), bo[i], 0);
      check($sformatf("reset_bit_valid i%0d", i), bv[i], 0);
      check($sformatf("reset_frame_done i%0d", i), fd[i], 0);
      check($sformatf("reset_underrun i%0d", i), ur[i], 0);
      check($sformatf("reset_in_ready i%0d", i), rdy[i], 0);
    end
    reset_n = 1'b1;
    idle_cycles(2);

    run_frame(0, 0, -1);
    idle_cycles(3);
    run_frame(1, 1, -1);
    run_frame(1, 2, -1);
    idle_cycles(5);
    check("underrun_sticky_idle", ur[1], 1);
    run_frame(1, 3, -1);
    run_frame(1, 0, -1);
    idle_cycles(2);
    run_frame(1, 0, 20);
    run_frame(1, 0, -1);
    run_frame(2, 0, -1);
    run_frame(2, 0, -1);
    run_frame(2, 2, -1);
    idle_cycles(1);
    run_frame(0, 2, -1);
    run_frame(0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
